kmc_alu: RTL and testbench

//  KMC11 ALU and BRG stage, directly upstream of the scratch pad: forms kmcALU, which the SP writes.
//  A operand is scratch pad read data; B operand is muxed from immediate, IBUS, MEM or BRG per the CRAM SRC field.

---
 rtl/kmc_pkg.sv | 64 ++++++
 rtl/kmc_alu_core.sv | 54 +++++
 rtl/kmc_alu.sv | 94 +++++++++
 tb/tb_kmc_alu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/kmc_pkg.sv
// Shared KMC11 definitions: CRAM field layout, SRC/DST/ALU encodings and field extract helpers.
// CRAM layout: [15:12] SRC, [11:8] DST, [7:0] immediate (ALU function in [3:0] for ALU-class words).
package kmc_pkg;

    typedef enum logic [3:0] {
        FN_ADD    = 4'd0,
        FN_ADDC   = 4'd1,
        FN_SUBC   = 4'd2,
        FN_INCA   = 4'd3,
        FN_APLUSC = 4'd4,
        FN_TWOA   = 4'd5,
        FN_TWOAC  = 4'd6,
        FN_DECA   = 4'd7,
        FN_SELA   = 4'd8,
        FN_SELB   = 4'd9,
        FN_ORNOT  = 4'd10,
        FN_AND    = 4'd11,
        FN_OR     = 4'd12,
        FN_XOR    = 4'd13,
        FN_SUB    = 4'd14,
        FN_SUBOC  = 4'd15
    } kmcAluFn_t;

    // Codes 0..4 are the MOV class; every other SRC code selects the ALU class.
    typedef enum logic [3:0] {
        SRC_IMMED = 4'd0,
        SRC_IBUS  = 4'd1,
        SRC_MEM   = 4'd2,
        SRC_BRG   = 4'd3,
        SRC_IBUSS = 4'd4,
        SRC_SP    = 4'd5
    } kmcSrc_t;

    typedef enum logic [3:0] {
        DST_NONE   = 4'd0,
        DST_SP     = 4'd1,
        DST_BRG    = 4'd2,
        DST_SPBRG  = 4'd3,
        DST_BRGSHR = 4'd4,
        DST_OBUS   = 4'd5,
        DST_MAR    = 4'd6
    } kmcDst_t;

    function automatic logic [3:0] cramSrc(input logic [15:0] cram);
        return cram[15:12];
    endfunction

    function automatic logic [3:0] cramDst(input logic [15:0] cram);
        return cram[11:8];
    endfunction

    function automatic logic [7:0] cramImm(input logic [15:0] cram);
        return cram[7:0];
    endfunction

    function automatic kmcAluFn_t cramAluFn(input logic [15:0] cram);
        return kmcAluFn_t'(cram[3:0]);
    endfunction

    function automatic logic isMovSrc(input logic [3:0] src);
        return src <= SRC_IBUSS;
    endfunction

endpackage

// File: rtl/kmc_alu_core.sv
// Combinational KMC11 ALU function unit: 16 functions over A/B/cin giving {carry, result, ovfl}.
// Subtraction is A + ~B + cin, so carry out means "no borrow".
module kmc_alu_core
    import kmc_pkg::*;
(
    input  kmcAluFn_t  fn,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] result,
    output logic       carry,
    output logic       ovfl
);

    logic [7:0] addend;
    logic       carryIn;
    logic       isArith;
    logic [7:0] logicRes;
    logic [8:0] sum;

    // NOTE: every output of this block gets a default first so no path through the case can infer a latch.
    always_comb begin
        addend   = 8'h00;
        carryIn  = 1'b0;
        isArith  = 1'b1;
        logicRes = 8'h00;
        unique case (fn)
            FN_ADD:    addend = b;
            FN_ADDC:   begin addend = b;  carryIn = cin;  end
            FN_SUBC:   begin addend = ~b; carryIn = cin;  end
            FN_INCA:   carryIn = 1'b1;
            FN_APLUSC: carryIn = cin;
            FN_TWOA:   addend = a;
            FN_TWOAC:  begin addend = a;  carryIn = cin;  end
            FN_DECA:   addend = 8'hFF;
            FN_SUB:    begin addend = ~b; carryIn = 1'b1; end
            FN_SUBOC:  addend = ~b;
            FN_SELA:   begin isArith = 1'b0; logicRes = a;      end
            FN_SELB:   begin isArith = 1'b0; logicRes = b;      end
            FN_ORNOT:  begin isArith = 1'b0; logicRes = a | ~b; end
            FN_AND:    begin isArith = 1'b0; logicRes = a & b;  end
            FN_OR:     begin isArith = 1'b0; logicRes = a | b;  end
            FN_XOR:    begin isArith = 1'b0; logicRes = a ^ b;  end
            default:   isArith = 1'b1;
        endcase
    end

    assign sum    = {1'b0, a} + {1'b0, addend} + {8'h00, carryIn};
    assign result = isArith ? sum[7:0] : logicRes;
    assign carry  = isArith & sum[8];
    // Overflow sees the effective (already inverted) addend, so subtract needs no special case.
    assign ovfl   = isArith & (a[7] == addend[7]) & (sum[7] != a[7]);

endmodule

// File: rtl/kmc_alu.sv
// KMC11 ALU/BRG stage: B-operand mux, MOV/ALU class decode, BRG register and C/Z(/V) flags.
// Define KMC_ALU_OVFL_EN to build the registered signed-overflow flag; otherwise kmcALUV is 0.
module kmc_alu
    import kmc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        kmcALUCLKEN,
    input  logic [15:0] kmcCRAM,
    input  logic [7:0]  kmcSP,
    input  logic [7:0]  kmcIBUS,
    input  logic [7:0]  kmcMEM,
    output logic [7:0]  kmcALU,
    output logic [7:0]  kmcBRG,
    output logic        kmcALUC,
    output logic        kmcALUZ,
    output logic        kmcALUV
);

    logic [3:0] src;
    logic [3:0] dst;
    logic       isMov;
    logic [7:0] movB;
    logic [7:0] coreResult;
    logic       coreCarry;
    logic       coreOvfl;
    logic       aluCarry;
    logic       aluOvfl;
    logic       aluZero;

    assign src   = cramSrc(kmcCRAM);
    assign dst   = cramDst(kmcCRAM);
    assign isMov = isMovSrc(src);

    always_comb begin
        movB = kmcBRG;
        unique case (src)
            SRC_IMMED:           movB = cramImm(kmcCRAM);
            SRC_IBUS, SRC_IBUSS: movB = kmcIBUS;
            SRC_MEM:             movB = kmcMEM;
            SRC_BRG:             movB = kmcBRG;
            default:             movB = kmcBRG;
        endcase
    end

    kmc_alu_core u_core (
        .fn     (cramAluFn(kmcCRAM)),
        .a      (kmcSP),
        .b      (kmcBRG),
        .cin    (kmcALUC),
        .result (coreResult),
        .carry  (coreCarry),
        .ovfl   (coreOvfl)
    );

    assign kmcALU   = isMov ? movB : coreResult;
    assign aluCarry = ~isMov & coreCarry;
    assign aluOvfl  = ~isMov & coreOvfl;
    assign aluZero  = (kmcALU == 8'h00);

    // NOTE: non-blocking assignments make BRG and the flags all sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kmcBRG  <= 8'h00;
            kmcALUC <= 1'b0;
            kmcALUZ <= 1'b0;
        end else if (kmcALUCLKEN) begin
            if (dst != DST_NONE) begin
                kmcALUC <= aluCarry;
                kmcALUZ <= aluZero;
            end
            case (dst)
                DST_BRG, DST_SPBRG: kmcBRG <= kmcALU;
                DST_BRGSHR:         kmcBRG <= {kmcALU[0], kmcBRG[7:1]};
                default:            kmcBRG <= kmcBRG;
            endcase
        end
    end

`ifdef KMC_ALU_OVFL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kmcALUV <= 1'b0;
        end else if (kmcALUCLKEN && dst != DST_NONE) begin
            kmcALUV <= aluOvfl;
        end
    end
`else
    logic unusedOvfl;
    assign unusedOvfl = aluOvfl;
    assign kmcALUV    = 1'b0;
`endif

endmodule

// File: tb/tb_kmc_alu.sv
// Scoreboard bench for kmc_alu: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Honours KMC_ALU_OVFL_EN so the V expectation matches the build under test.
module tb_kmc_alu;
    import kmc_pkg::*;

`ifdef KMC_ALU_OVFL_EN
    localparam bit ovflEn = 1'b1;
`else
    localparam bit ovflEn = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] alu;
        logic [7:0] brg;
        logic       c;
        logic       z;
        logic       v;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        kmcALUCLKEN;
    logic [15:0] kmcCRAM;
    logic [7:0]  kmcSP;
    logic [7:0]  kmcIBUS;
    logic [7:0]  kmcMEM;
    logic [7:0]  kmcALU;
    logic [7:0]  kmcBRG;
    logic        kmcALUC;
    logic        kmcALUZ;
    logic        kmcALUV;

    expect_t sbQ[$];
    int      total = 0;
    int      bad   = 0;

    kmc_alu dut (
        .clk         (clk),
        .rst         (rst),
        .kmcALUCLKEN (kmcALUCLKEN),
        .kmcCRAM     (kmcCRAM),
        .kmcSP       (kmcSP),
        .kmcIBUS     (kmcIBUS),
        .kmcMEM      (kmcMEM),
        .kmcALU      (kmcALU),
        .kmcBRG      (kmcBRG),
        .kmcALUC     (kmcALUC),
        .kmcALUZ     (kmcALUZ),
        .kmcALUV     (kmcALUV)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] low);
        return {src, dst, low};
    endfunction

    function automatic logic [15:0] alu(input logic [3:0] dst, input logic [3:0] fn);
        return {SRC_SP, dst, 4'h0, fn};
    endfunction

    // Combinational result is checked mid-cycle, registers just after the updating edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check({e.name, "/alu"}, kmcALU, e.alu);
                @(posedge clk);
                #1;
                check({e.name, "/brg"}, kmcBRG, e.brg);
                check({e.name, "/c"}, {7'h0, kmcALUC}, {7'h0, e.c});
                check({e.name, "/z"}, {7'h0, kmcALUZ}, {7'h0, e.z});
                check({e.name, "/v"}, {7'h0, kmcALUV}, {7'h0, ovflEn ? e.v : 1'b0});
            end
        end
    end

    task automatic step(input string name, input logic [15:0] cram, input logic [7:0] sp,
                        input logic [7:0] ibus, input logic [7:0] mem, input logic en,
                        input logic [7:0] eAlu, input logic [7:0] eBrg,
                        input logic eC, input logic eZ, input logic eV);
        expect_t e;
        @(posedge clk);
        #2;
        kmcCRAM     = cram;
        kmcSP       = sp;
        kmcIBUS     = ibus;
        kmcMEM      = mem;
        kmcALUCLKEN = en;
        e.name = name; e.alu = eAlu; e.brg = eBrg; e.c = eC; e.z = eZ; e.v = eV;
        sbQ.push_back(e);
        @(posedge clk);
        #3;
        kmcALUCLKEN = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        kmcALUCLKEN = 1'b0;
        kmcCRAM     = 16'h0000;
        kmcSP       = 8'h00;
        kmcIBUS     = 8'h00;
        kmcMEM      = 8'h00;

        #3 rst = 1'b1;
        #1;
        check("por/brg", kmcBRG, 8'h00);
        check("por/c", {7'h0, kmcALUC}, 8'h00);
        check("por/z", {7'h0, kmcALUZ}, 8'h00);
        check("por/v", {7'h0, kmcALUV}, 8'h00);
        #10 rst = 1'b0;

        // Load BRG=5A, C=1, then pulse reset between edges
        step("mov5a",  mk(SRC_IMMED, DST_BRG, 8'h5A), 8'h00, 8'h00, 8'h00, 1'b1, 8'h5A, 8'h5A, 0, 0, 0);
        step("addff",  alu(DST_SP, FN_ADD),          8'hFF, 8'h00, 8'h00, 1'b1, 8'h59, 8'h5A, 1, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst/brg", kmcBRG, 8'h00);
        check("arst/c", {7'h0, kmcALUC}, 8'h00);
        check("arst/z", {7'h0, kmcALUZ}, 8'h00);
        #1 rst = 1'b0;

        step("mov80",   mk(SRC_IMMED, DST_BRG, 8'h80), 8'h00, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80, 0, 0, 0);
        step("mov33en0", mk(SRC_IMMED, DST_BRG, 8'h33), 8'h00, 8'h00, 8'h00, 1'b0, 8'h33, 8'h80, 0, 0, 0);

        step("mov01",  mk(SRC_IMMED, DST_BRG, 8'h01), 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 0, 0, 0);
        step("addwrap", alu(DST_SP, FN_ADD),          8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 8'h01, 1, 1, 0);
        step("addc",   alu(DST_SP, FN_ADDC),          8'h10, 8'h00, 8'h00, 1'b1, 8'h12, 8'h01, 0, 0, 0);

        step("mov06",  mk(SRC_IMMED, DST_BRG, 8'h06), 8'h00, 8'h00, 8'h00, 1'b1, 8'h06, 8'h06, 0, 0, 0);
        step("sub5m6", alu(DST_SP, FN_SUB),           8'h05, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h06, 0, 0, 0);
        step("sub6m6", alu(DST_SP, FN_SUB),           8'h06, 8'h00, 8'h00, 1'b1, 8'h00, 8'h06, 1, 1, 0);
        step("mov05",  mk(SRC_IMMED, DST_BRG, 8'h05), 8'h00, 8'h00, 8'h00, 1'b1, 8'h05, 8'h05, 0, 0, 0);
        step("suboc",  alu(DST_SP, FN_SUBOC),         8'h06, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1, 1, 0);
        step("deca0",  alu(DST_SP, FN_DECA),          8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h05, 0, 0, 0);
        step("incaff", alu(DST_SP, FN_INCA),          8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 8'h05, 1, 1, 0);

        step("mov81",  mk(SRC_IMMED, DST_BRG, 8'h81), 8'h00, 8'h00, 8'h00, 1'b1, 8'h81, 8'h81, 0, 0, 0);
        step("brgshr", alu(DST_BRGSHR, FN_SELA),      8'h01, 8'h00, 8'h00, 1'b1, 8'h01, 8'hC0, 0, 0, 0);
        step("movbrg", mk(SRC_BRG, DST_BRG, 8'h00),   8'h00, 8'h00, 8'h00, 1'b1, 8'hC0, 8'hC0, 0, 0, 0);
        step("spbrg",  mk(SRC_IBUS, DST_SPBRG, 8'h00), 8'h00, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5, 0, 0, 0);
        step("incobus", alu(DST_OBUS, FN_INCA),       8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 8'hA5, 1, 1, 0);
        step("memnone", mk(SRC_MEM, DST_NONE, 8'h00), 8'h00, 8'h00, 8'h3C, 1'b1, 8'h3C, 8'hA5, 1, 1, 0);
        step("xor",    alu(DST_SP, FN_XOR),           8'hF0, 8'h00, 8'h00, 1'b1, 8'h55, 8'hA5, 0, 0, 0);
        step("ornot",  alu(DST_SP, FN_ORNOT),         8'h00, 8'h00, 8'h00, 1'b1, 8'h5A, 8'hA5, 0, 0, 0);
        step("and",    alu(DST_SP, FN_AND),           8'h0F, 8'h00, 8'h00, 1'b1, 8'h05, 8'hA5, 0, 0, 0);
        step("or",     alu(DST_SP, FN_OR),            8'h0F, 8'h00, 8'h00, 1'b1, 8'hAF, 8'hA5, 0, 0, 0);
        step("selb",   alu(DST_SP, FN_SELB),          8'h0F, 8'h00, 8'h00, 1'b1, 8'hA5, 8'hA5, 0, 0, 0);
        step("twoa",   alu(DST_SP, FN_TWOA),          8'h81, 8'h00, 8'h00, 1'b1, 8'h02, 8'hA5, 1, 0, 1);
        step("twoac",  alu(DST_SP, FN_TWOAC),         8'h40, 8'h00, 8'h00, 1'b1, 8'h81, 8'hA5, 0, 0, 1);
        step("aplusc", alu(DST_SP, FN_APLUSC),        8'hFF, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hA5, 0, 0, 0);
        step("subc",   alu(DST_SP, FN_SUBC),          8'h10, 8'h00, 8'h00, 1'b1, 8'h6A, 8'hA5, 0, 0, 0);

        step("mov01b", mk(SRC_IMMED, DST_BRG, 8'h01), 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 0, 0, 0);
        step("ovfl",   alu(DST_SP, FN_ADD),           8'h7F, 8'h00, 8'h00, 1'b1, 8'h80, 8'h01, 0, 0, 1);
        step("ibuss",  mk(SRC_IBUSS, DST_SP, 8'h00),  8'h00, 8'h11, 8'h00, 1'b1, 8'h11, 8'h01, 0, 0, 0);

        for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(posedge clk);
        if (sbQ.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sbQ.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
